// File: rtl/sram_responder.sv
// Single-cycle SRAM responder serving the core's fetch and data ports from one word array.
// Define CONFREG_EN to add the MMIO confreg window (timer, LED, switch, scratch) on the data port.
module sram_responder #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic              cfg_hit;
  logic [31:0]       cfg_rdata;
  logic              mem_we;

  assign inst_idx = inst_sram_addr[ADDR_W+1:2];
  assign data_idx = data_sram_addr[ADDR_W+1:2];
  assign mem_we   = data_sram_en && (data_sram_we != 4'b0000) && !cfg_hit;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
    return result;
  endfunction

  // The array is never reset; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[data_idx] <= merge_lanes(mem[data_idx], data_sram_wdata, data_sram_we);
  end

  // Read data is taken before this edge's write, giving read-before-write on both ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (inst_sram_en)
        inst_sram_rdata <= mem[inst_idx];
      if (data_sram_en)
        data_sram_rdata <= cfg_hit ? cfg_rdata : mem[data_idx];
    end
  end

  logic unused_inst;
  assign unused_inst = ^{inst_sram_we, inst_sram_wdata,
                         inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

`ifdef CONFREG_EN
  logic [31:0] timer;
  logic [15:0] led;
  logic [31:0] scratch;
  logic        cfg_wr;
  logic [15:0] cfg_off;

  assign cfg_hit = data_sram_en && (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign cfg_wr  = cfg_hit && (data_sram_we != 4'b0000);
  assign cfg_off = data_sram_addr[15:0];
  assign led_out = led;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_off)
      16'h0000: cfg_rdata = timer;
      16'h0004: cfg_rdata = {16'b0, led};
      16'h0008: cfg_rdata = {16'b0, switch_in};
      16'h000c: cfg_rdata = scratch;
      default:  cfg_rdata = '0;
    endcase
  end

  // A timer write overrides that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      led     <= '0;
      scratch <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (cfg_wr && cfg_off == 16'h0000)
        timer <= merge_lanes(timer, data_sram_wdata, data_sram_we);
      if (cfg_wr && cfg_off == 16'h0004) begin
        if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
      end
      if (cfg_wr && cfg_off == 16'h000c)
        scratch <= merge_lanes(scratch, data_sram_wdata, data_sram_we);
    end
  end
`else
  assign cfg_hit   = 1'b0;
  assign cfg_rdata = '0;
  assign led_out   = '0;

  logic unused_data;
  assign unused_data = ^{switch_in, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: vector table, scoreboard queue, reset and confreg sequences.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        ien;
    logic [31:0] iaddr;
    logic        ichk;
    logic [31:0] iexp;
    logic        den;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic        dchk;
    logic [31:0] dexp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  logic [31:0] model [int];

  sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input string name,
                              input logic ien, input logic [31:0] iaddr,
                              input logic ichk, input logic [31:0] iexp,
                              input logic den, input logic [3:0] we,
                              input logic [31:0] daddr, input logic [31:0] wdata,
                              input logic dchk, input logic [31:0] dexp);
    vec_t v;
    v = '{name, ien, iaddr, ichk, iexp, den, we, daddr, wdata, dchk, dexp};
    vecs.push_back(v);
  endfunction

  // Drive one request, queue its expectation, and compare once the edge has produced output.
  task automatic apply_stimulus(input vec_t v);
    vec_t e;
    inst_sram_en    = v.ien;
    inst_sram_addr  = v.iaddr;
    data_sram_en    = v.den;
    data_sram_we    = v.we;
    data_sram_addr  = v.daddr;
    data_sram_wdata = v.wdata;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.ichk) check_output({e.name, ".inst"}, inst_sram_rdata, e.iexp);
    if (e.dchk) check_output({e.name, ".data"}, data_sram_rdata, e.dexp);
  endtask

  task automatic data_op(input string name, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic dchk, input logic [31:0] dexp);
    vec_t v;
    v = '{name, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, we, addr, wdata, dchk, dexp};
    apply_stimulus(v);
  endtask

  initial begin
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_we    = 1'b0;
    inst_sram_addr  = '0;
    inst_sram_wdata = 32'hffff_ffff;
    data_sram_en    = 1'b0;
    data_sram_we    = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    switch_in       = 16'h0000;

    #12;
    check_output("reset.inst", inst_sram_rdata, 32'h0);
    check_output("reset.data", data_sram_rdata, 32'h0);
    check_output("reset.led", {16'h0, led_out}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    //   name           ien iaddr         ichk iexp           den we    daddr          wdata          dchk dexp
    add("st_full",      0, 32'h0,         0, 32'h0,          1, 4'hf, 32'h1c00_0100, 32'h1122_3344, 0, 32'h0);
    add("st_byte1",     0, 32'h0,         0, 32'h0,          1, 4'h2, 32'h1c00_0100, 32'haabb_ccdd, 1, 32'h1122_3344);
    add("ld_merge",     0, 32'h0,         0, 32'h0,          1, 4'h0, 32'h1c00_0100, 32'h0,         1, 32'h1122_cc44);
    add("alias_st",     0, 32'h0,         0, 32'h0,          1, 4'hf, 32'h1c04_0100, 32'h1234_5678, 1, 32'h1122_cc44);
    add("alias_ld",     0, 32'h0,         0, 32'h0,          1, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h1234_5678);
    add("st_top",       0, 32'h0,         0, 32'h0,          1, 4'hf, 32'h0003_fffc, 32'hcafe_f00d, 0, 32'h0);
    add("st_bot",       0, 32'h0,         0, 32'h0,          1, 4'hf, 32'h0000_0000, 32'h0bad_f00d, 0, 32'h0);
    add("ld_top",       0, 32'h0,         0, 32'h0,          1, 4'h0, 32'h0003_fffc, 32'h0,         1, 32'hcafe_f00d);
    add("dual_rd",      1, 32'h0003_fffc, 1, 32'hcafe_f00d,  1, 4'h0, 32'h0000_0000, 32'h0,         1, 32'h0bad_f00d);
    add("st_5",         0, 32'h0,         1, 32'hcafe_f00d,  1, 4'hf, 32'h0000_0200, 32'h0000_0005, 0, 32'h0);
    add("ld_5",         0, 32'h0,         0, 32'h0,          1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'h0000_0005);
    add("hold1",        0, 32'h0000_0000, 1, 32'hcafe_f00d,  0, 4'h0, 32'h0000_0000, 32'h0,         1, 32'h0000_0005);
    add("hold2",        0, 32'h0000_0100, 1, 32'hcafe_f00d,  0, 4'hf, 32'h0000_0200, 32'h9999_9999, 1, 32'h0000_0005);
    add("hold3",        0, 32'h0,         1, 32'hcafe_f00d,  0, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h0000_0005);
    add("st_lane3",     0, 32'h0,         0, 32'h0,          1, 4'h8, 32'h0000_0200, 32'h7700_0000, 1, 32'h0000_0005);
    add("ld_lane3",     0, 32'h0,         0, 32'h0,          1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'h7700_0005);
    add("st_old",       0, 32'h0,         0, 32'h0,          1, 4'hf, 32'h0000_0100, 32'hdead_beef, 1, 32'h1234_5678);
    add("rbw",          1, 32'h0000_0100, 1, 32'hdead_beef,  1, 4'hf, 32'h0000_0100, 32'h0,         1, 32'hdead_beef);
    add("fetch_new",    1, 32'h0000_0100, 1, 32'h0,          0, 4'h0, 32'h0,         32'h0,         1, 32'hdead_beef);
    add("low_bits",     1, 32'h0000_0103, 1, 32'h0,          1, 4'h0, 32'h0000_0202, 32'h0,         1, 32'h7700_0005);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Random lane-masked traffic over a small window, checked against a word model.
    for (int w = 0; w < 8; w++) begin
      model[w] = $urandom;
      data_op("rnd_init", 4'hf, 32'h0000_1000 + 32'(w * 4), model[w], 1'b0, 32'h0);
    end
    for (int n = 0; n < 60; n++) begin
      int          w;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [31:0] nxt;
      w   = int'($urandom_range(0, 7));
      we  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      nxt = model[w];
      for (int b = 0; b < 4; b++)
        if (we[b]) nxt[8*b +: 8] = wd[8*b +: 8];
      data_op("rnd", we, 32'h0000_1000 + 32'(w * 4), wd, 1'b1, model[w]);
      model[w] = nxt;
    end

    // Asynchronous reset between edges, with a store held on the bus during reset.
    #3;
    reset = 1'b1;
    #1;
    check_output("midrst.inst", inst_sram_rdata, 32'h0);
    check_output("midrst.data", data_sram_rdata, 32'h0);
    check_output("midrst.led", {16'h0, led_out}, 32'h0);
    data_sram_en    = 1'b1;
    data_sram_we    = 4'hf;
    data_sram_addr  = 32'h0000_0200;
    data_sram_wdata = 32'heeee_eeee;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset        = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
`ifdef CONFREG_EN
    data_op("timer_rel", 4'h0, 32'hbfaf_0000, 32'h0, 1'b1, 32'h0);
`endif
    data_op("rst_nowr", 4'h0, 32'h0000_0200, 32'h0, 1'b1, 32'h7700_0005);

`ifdef CONFREG_EN
    data_op("timer_wr", 4'hf, 32'hbfaf_0000, 32'hffff_fffe, 1'b0, 32'h0);
    data_op("timer_0",  4'h0, 32'hbfaf_0000, 32'h0, 1'b1, 32'hffff_fffe);
    data_op("timer_1",  4'h0, 32'hbfaf_0000, 32'h0, 1'b1, 32'hffff_ffff);
    data_op("timer_2",  4'h0, 32'hbfaf_0000, 32'h0, 1'b1, 32'h0000_0000);
    data_op("led_wr",   4'h1, 32'hbfaf_0004, 32'h0000_00ab, 1'b1, 32'h0);
    check_output("led_out", {16'h0, led_out}, 32'h0000_00ab);
    data_op("led_rd",   4'h0, 32'hbfaf_0004, 32'h0, 1'b1, 32'h0000_00ab);
    data_op("scr_wr",   4'h5, 32'hbfaf_000c, 32'h1122_3344, 1'b1, 32'h0);
    data_op("scr_rd",   4'h0, 32'hbfaf_000c, 32'h0, 1'b1, 32'h0022_0044);
    data_op("hole_rd",  4'h0, 32'hbfaf_0010, 32'h0, 1'b1, 32'h0);
    data_op("alias_pre", 4'hf, 32'h0003_0008, 32'h3141_5926, 1'b0, 32'h0);
    switch_in = 16'h5a5a;
    data_op("sw_rd",    4'h0, 32'hbfaf_0008, 32'h0, 1'b1, 32'h0000_5a5a);
    data_op("sw_wr",    4'hf, 32'hbfaf_0008, 32'h9999_9999, 1'b1, 32'h0000_5a5a);
    data_op("sw_keep",  4'h0, 32'h0003_0008, 32'h0, 1'b1, 32'h3141_5926);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
